marlann_smem_arbiter: RTL and testbench

Shares the single-port sequencer memory (SPRAM, 32-bit words, 1-cycle read latency) between two requesters. One is the sequencer instruction fetch port, which is read-only. The other is the host loader port, which reads and writes program/data words. The block sits between both requesters and the memory macro and serialises their accesses with a 3-state access FSM and round-robin or host-priority arbitration.

---
 rtl/marlann_smem_arbiter_if.sv | 62 ++++++
 rtl/marlann_smem_arbiter.sv | 104 ++++++++++
 tb/tb_marlann_smem_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/marlann_smem_arbiter_if.sv
// Sequencer memory arbiter bus: seq fetch port, host loader port
// and the single-port memory macro side, bundled as one interface.
interface marlann_smem_arbiter_if #(
  parameter int AW = 16
);
  logic        seq_valid;
  logic        seq_ready;
  logic [15:0] seq_addr;
  logic [31:0] seq_data;

  logic        host_valid;
  logic        host_ready;
  logic        host_write;
  logic [3:0]  host_wstrb;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;

  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  seq_valid,
    input  seq_addr,
    output seq_ready,
    output seq_data,
    input  host_valid,
    input  host_write,
    input  host_wstrb,
    input  host_addr,
    input  host_wdata,
    output host_ready,
    output host_rdata,
    output mem_en,
    output mem_wen,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output seq_valid,
    output seq_addr,
    input  seq_ready,
    input  seq_data,
    output host_valid,
    output host_write,
    output host_wstrb,
    output host_addr,
    output host_wdata,
    input  host_ready,
    input  host_rdata,
    input  mem_en,
    input  mem_wen,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/marlann_smem_arbiter.sv
// Serialises sequencer fetches and host loads onto one SPRAM,
// one access per three cycles, round-robin or host-priority.
module marlann_smem_arbiter #(
  parameter int AW        = 16,
  parameter bit HOST_PRIO = 1'b0
) (
  input logic clock,
  input logic reset,
  marlann_smem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic          grant_host;
  logic          last_host;
  logic          seq_ready_q;
  logic          host_ready_q;
  logic          mem_en_q;
  logic [3:0]    mem_wen_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic          req_any;
  logic          pick_host;
  logic [AW-1:0] pick_addr;
  logic [3:0]    pick_wen;

  assign req_any = bus.seq_valid | bus.host_valid;

  // Host wins when alone, when prioritised, or when seq went last.
  assign pick_host = bus.host_valid
                   & (~bus.seq_valid | HOST_PRIO | ~last_host);

  assign pick_addr = pick_host ? bus.host_addr[AW-1:0]
                               : bus.seq_addr[AW-1:0];

  assign pick_wen = (pick_host & bus.host_write)
                  ? bus.host_wstrb : 4'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      grant_host   <= 1'b0;
      last_host    <= 1'b1;
      seq_ready_q  <= 1'b0;
      host_ready_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wen_q    <= 4'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_any) begin
            mem_en_q    <= 1'b1;
            mem_addr_q  <= pick_addr;
            mem_wen_q   <= pick_wen;
            mem_wdata_q <= bus.host_wdata;
            grant_host  <= pick_host;
            last_host   <= pick_host;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q     <= 1'b0;
          mem_wen_q    <= 4'h0;
          seq_ready_q  <= ~grant_host;
          host_ready_q <= grant_host;
          state        <= RESP;
        end
        RESP: begin
          seq_ready_q  <= 1'b0;
          host_ready_q <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.seq_ready  = seq_ready_q;
  assign bus.host_ready = host_ready_q;
  assign bus.seq_data   = bus.mem_rdata;
  assign bus.host_rdata = bus.mem_rdata;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  a_one_ready: assert property (
    @(posedge clock) !(seq_ready_q && host_ready_q)
  );

  a_seq_no_write: assert property (
    @(posedge clock) disable iff (reset)
    (state == ACCESS && !grant_host) |-> (mem_wen_q == 4'h0)
  );

endmodule

// File: tb/tb_marlann_smem_arbiter.sv
// Bench for marlann_smem_arbiter: directed scenarios plus random
// traffic on a round-robin and a host-priority instance.
module tb_marlann_smem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;

  logic        seq_valid  = 1'b0;
  logic [15:0] seq_addr   = 16'h0;
  logic        host_valid = 1'b0;
  logic        host_write = 1'b0;
  logic [3:0]  host_wstrb = 4'h0;
  logic [15:0] host_addr  = 16'h0;
  logic [31:0] host_wdata = 32'h0;
  logic [31:0] mem_rdata  = 32'h0;

  logic        pl_en   = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [31:0] pl_data = 32'h0;
  logic [31:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  marlann_smem_arbiter_if #(.AW(16)) b0 ();
  marlann_smem_arbiter_if #(.AW(16)) b1 ();

  assign b0.seq_valid  = seq_valid & ~sel;
  assign b0.seq_addr   = seq_addr;
  assign b0.host_valid = host_valid & ~sel;
  assign b0.host_write = host_write;
  assign b0.host_wstrb = host_wstrb;
  assign b0.host_addr  = host_addr;
  assign b0.host_wdata = host_wdata;
  assign b0.mem_rdata  = mem_rdata;

  assign b1.seq_valid  = seq_valid & sel;
  assign b1.seq_addr   = seq_addr;
  assign b1.host_valid = host_valid & sel;
  assign b1.host_write = host_write;
  assign b1.host_wstrb = host_wstrb;
  assign b1.host_addr  = host_addr;
  assign b1.host_wdata = host_wdata;
  assign b1.mem_rdata  = mem_rdata;

  marlann_smem_arbiter #(.AW(16), .HOST_PRIO(1'b0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (b0)
  );

  marlann_smem_arbiter #(.AW(16), .HOST_PRIO(1'b1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  wire        m_en    = sel ? b1.mem_en     : b0.mem_en;
  wire [3:0]  m_wen   = sel ? b1.mem_wen    : b0.mem_wen;
  wire [15:0] m_addr  = sel ? b1.mem_addr   : b0.mem_addr;
  wire [31:0] m_wdata = sel ? b1.mem_wdata  : b0.mem_wdata;
  wire        s_rdy   = sel ? b1.seq_ready  : b0.seq_ready;
  wire        h_rdy   = sel ? b1.host_ready : b0.host_ready;
  wire [31:0] s_data  = sel ? b1.seq_data   : b0.seq_data;
  wire [31:0] h_data  = sel ? b1.host_rdata : b0.host_rdata;

  // SPRAM model: 1-cycle read latency, read-before-write, byte enables
  always @(posedge clock) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (m_en === 1'b1) begin
      mem_rdata <= mem[m_addr];
      for (int i = 0; i < 4; i++)
        if (m_wen[i]) mem[m_addr][8*i +: 8] <= m_wdata[8*i +: 8];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    seq_valid = 1'b0;
    host_valid = 1'b0;
    step();
    step();
    checks++;
    if ({s_rdy, h_rdy, m_en, m_wen} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {s_rdy, h_rdy, m_en, m_wen});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({s_rdy, h_rdy, m_en, m_wen} !== 7'b0) begin
      errors++;
      $display("FAIL idle_no_req got %b want 0",
               {s_rdy, h_rdy, m_en, m_wen});
    end
  endtask

  task automatic test_seq_read();
    preload(16'h0010, 32'hDEADBEEF);
    seq_valid = 1'b1;
    seq_addr  = 16'h0010;
    step();
    checks++;
    if ({m_en, m_addr, m_wen, s_rdy, h_rdy}
        !== {1'b1, 16'h0010, 4'h0, 2'b00}) begin
      errors++;
      $display("FAIL seq_access got en=%b addr=%h wen=%h rdy=%b%b",
               m_en, m_addr, m_wen, s_rdy, h_rdy);
    end
    seq_addr = 16'h0020;
    step();
    checks++;
    if ({s_rdy, h_rdy} !== 2'b10 || s_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL seq_resp got rdy=%b%b data=%h want 10 deadbeef",
               s_rdy, h_rdy, s_data);
    end
    seq_valid = 1'b0;
    step();
    checks++;
    if ({s_rdy, h_rdy, m_en} !== 3'b000) begin
      errors++;
      $display("FAIL seq_after got %b want 000", {s_rdy, h_rdy, m_en});
    end
  endtask

  task automatic test_host_write_seq_read();
    host_valid = 1'b1;
    host_write = 1'b1;
    host_addr  = 16'd5;
    host_wdata = 32'h12345678;
    host_wstrb = 4'hF;
    step();
    checks++;
    if ({m_en, m_addr, m_wen, m_wdata}
        !== {1'b1, 16'd5, 4'hF, 32'h12345678}) begin
      errors++;
      $display("FAIL hw_access got en=%b addr=%h wen=%h wdata=%h",
               m_en, m_addr, m_wen, m_wdata);
    end
    host_wdata = 32'h0;
    step();
    checks++;
    if ({s_rdy, h_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL hw_ready got %b want 01", {s_rdy, h_rdy});
    end
    host_valid = 1'b0;
    host_write = 1'b0;
    step();
    seq_valid = 1'b1;
    seq_addr  = 16'd5;
    step();
    step();
    checks++;
    if ({s_rdy, h_rdy} !== 2'b10 || s_data !== 32'h12345678) begin
      errors++;
      $display("FAIL hw_readback got rdy=%b%b data=%h want 10 12345678",
               s_rdy, h_rdy, s_data);
    end
    seq_valid = 1'b0;
    step();
  endtask

  task automatic test_partial_write();
    preload(16'd7, 32'hAABBCCDD);
    host_valid = 1'b1;
    host_write = 1'b1;
    host_addr  = 16'd7;
    host_wdata = 32'h11223344;
    host_wstrb = 4'h3;
    step();
    checks++;
    if ({m_en, m_wen} !== {1'b1, 4'h3}) begin
      errors++;
      $display("FAIL pw_wen got en=%b wen=%h want 1 3", m_en, m_wen);
    end
    step();
    host_valid = 1'b0;
    host_write = 1'b0;
    step();
    host_valid = 1'b1;
    host_wstrb = 4'hF;
    step();
    checks++;
    if ({m_en, m_wen} !== {1'b1, 4'h0}) begin
      errors++;
      $display("FAIL pr_wen got en=%b wen=%h want 1 0", m_en, m_wen);
    end
    step();
    checks++;
    if ({s_rdy, h_rdy} !== 2'b01 || h_data !== 32'hAABB3344) begin
      errors++;
      $display("FAIL pw_readback got rdy=%b%b data=%h want 01 aabb3344",
               s_rdy, h_rdy, h_data);
    end
    host_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_strobe();
    preload(16'd9, 32'hCAFEF00D);
    host_valid = 1'b1;
    host_write = 1'b1;
    host_addr  = 16'd9;
    host_wdata = 32'h0;
    host_wstrb = 4'h0;
    step();
    checks++;
    if ({m_en, m_wen} !== {1'b1, 4'h0}) begin
      errors++;
      $display("FAIL zs_access got en=%b wen=%h want 1 0", m_en, m_wen);
    end
    step();
    checks++;
    if ({s_rdy, h_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL zs_ready got %b want 01", {s_rdy, h_rdy});
    end
    host_valid = 1'b0;
    host_write = 1'b0;
    step();
    checks++;
    if (mem[9] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL zs_mem got %h want cafef00d", mem[9]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    reset      = 1'b1;
    seq_valid  = 1'b1;
    host_valid = 1'b1;
    host_write = 1'b0;
    seq_addr   = 16'd1;
    host_addr  = 16'd2;
    step();
    step();
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      e = 2'b00;
      if (c % 3 == 2) e = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({s_rdy, h_rdy} !== e || m_en !== (c % 3 == 1)) begin
        errors++;
        $display("FAIL rr_cycle%0d got rdy=%b en=%b want %b %b",
                 c, {s_rdy, h_rdy}, m_en, e, (c % 3 == 1));
      end
    end
    seq_valid  = 1'b0;
    host_valid = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_reset_access();
    preload(16'h0030, 32'h01020304);
    seq_valid = 1'b1;
    seq_addr  = 16'h0030;
    step();
    checks++;
    if (m_en !== 1'b1) begin
      errors++;
      $display("FAIL ra_access got en=%b want 1", m_en);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    seq_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({s_rdy, h_rdy, m_en, m_wen} !== 7'b0) begin
        errors++;
        $display("FAIL ra_abort%0d got %b want 0", i,
                 {s_rdy, h_rdy, m_en, m_wen});
      end
      step();
    end
    seq_valid = 1'b1;
    step();
    checks++;
    if ({m_en, m_addr} !== {1'b1, 16'h0030}) begin
      errors++;
      $display("FAIL ra_retry_en got en=%b addr=%h", m_en, m_addr);
    end
    step();
    checks++;
    if ({s_rdy, h_rdy} !== 2'b10 || s_data !== 32'h01020304) begin
      errors++;
      $display("FAIL ra_retry got rdy=%b%b data=%h want 10 01020304",
               s_rdy, h_rdy, s_data);
    end
    seq_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_host_prio();
    logic [1:0] e;
    reset      = 1'b1;
    seq_valid  = 1'b1;
    host_valid = 1'b1;
    host_write = 1'b0;
    seq_addr   = 16'd1;
    host_addr  = 16'd2;
    step();
    step();
    reset = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c <= 8) e = (c % 3 == 2) ? 2'b01 : 2'b00;
      else        e = (c == 11) ? 2'b10 : 2'b00;
      checks++;
      if ({s_rdy, h_rdy} !== e) begin
        errors++;
        $display("FAIL hp_cycle%0d got %b want %b", c, {s_rdy, h_rdy}, e);
      end
      if (c == 8) host_valid = 1'b0;
    end
    seq_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_random(input bit prio, input int ncyc);
    logic [31:0] ref_mem [0:63];
    int          free_at, en_at, rdy_at;
    bit          last_host, win_host, s_busy, h_busy, exp_read;
    logic [15:0] e_addr;
    logic [3:0]  e_wen;
    logic [31:0] e_wdata, e_rdata, got;
    logic [1:0]  e_rdy;
    seq_valid  = 1'b0;
    host_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      preload(16'(i), ref_mem[i]);
    end
    free_at = 0; en_at = -1; rdy_at = -1;
    last_host = 1'b1; win_host = 1'b0;
    s_busy = 1'b0; h_busy = 1'b0; exp_read = 1'b0;
    e_addr = '0; e_wen = '0; e_wdata = '0; e_rdata = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) step();
      checks++;
      if (m_en !== (c == en_at)) begin
        errors++;
        $display("FAIL rnd%0d_en c=%0d got %b want %b",
                 prio, c, m_en, (c == en_at));
      end
      if (c == en_at) begin
        checks++;
        if ({m_addr, m_wen} !== {e_addr, e_wen}) begin
          errors++;
          $display("FAIL rnd%0d_acc c=%0d got %h/%h want %h/%h",
                   prio, c, m_addr, m_wen, e_addr, e_wen);
        end
        if (e_wen != 4'h0) begin
          checks++;
          if (m_wdata !== e_wdata) begin
            errors++;
            $display("FAIL rnd%0d_wdata c=%0d got %h want %h",
                     prio, c, m_wdata, e_wdata);
          end
        end
      end
      e_rdy = (c == rdy_at) ? (win_host ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if ({s_rdy, h_rdy} !== e_rdy) begin
        errors++;
        $display("FAIL rnd%0d_rdy c=%0d got %b want %b",
                 prio, c, {s_rdy, h_rdy}, e_rdy);
      end
      if (c == rdy_at && exp_read) begin
        got = win_host ? h_data : s_data;
        checks++;
        if (got !== e_rdata) begin
          errors++;
          $display("FAIL rnd%0d_data c=%0d got %h want %h",
                   prio, c, got, e_rdata);
        end
      end
      if (c == rdy_at) begin
        if (win_host) begin h_busy = 1'b0; host_valid = 1'b0; end
        else          begin s_busy = 1'b0; seq_valid  = 1'b0; end
      end
      if (s_busy) begin
        if (seq_valid && $urandom_range(0, 3) == 0) seq_valid = 1'b0;
        seq_addr = 16'($urandom_range(0, 63));
      end else if (seq_valid) begin
        if ($urandom_range(0, 9) == 0) seq_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        seq_valid = 1'b1;
        seq_addr  = 16'($urandom_range(0, 63));
      end
      if (h_busy) begin
        if (host_valid && $urandom_range(0, 3) == 0) host_valid = 1'b0;
        host_addr  = 16'($urandom_range(0, 63));
        host_wdata = $urandom;
        host_wstrb = 4'($urandom_range(0, 15));
      end else if (host_valid) begin
        if ($urandom_range(0, 9) == 0) host_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        host_valid = 1'b1;
        host_write = 1'($urandom_range(0, 1));
        host_addr  = 16'($urandom_range(0, 63));
        host_wdata = $urandom;
        host_wstrb = 4'($urandom_range(0, 15));
      end
      // next slot opens three cycles after each grant
      if (c >= free_at && (seq_valid || host_valid)) begin
        win_host  = host_valid && (!seq_valid || prio || !last_host);
        last_host = win_host;
        en_at   = c + 1;
        rdy_at  = c + 2;
        free_at = c + 3;
        e_addr  = win_host ? host_addr : seq_addr;
        e_wen   = (win_host && host_write) ? host_wstrb : 4'h0;
        e_wdata = host_wdata;
        exp_read = !(win_host && host_write);
        e_rdata = ref_mem[e_addr[5:0]];
        for (int b = 0; b < 4; b++)
          if (e_wen[b]) ref_mem[e_addr[5:0]][8*b +: 8] = host_wdata[8*b +: 8];
        if (win_host) h_busy = 1'b1;
        else          s_busy = 1'b1;
      end
    end
    seq_valid  = 1'b0;
    host_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_seq_read();
    test_host_write_seq_read();
    test_partial_write();
    test_zero_strobe();
    test_round_robin();
    test_reset_access();
    test_random(1'b0, 400);
    sel = 1'b1;
    test_host_prio();
    test_random(1'b1, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
